serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial subtractor computing `a_i - b_i` under one of three number formats (unsigned, 1's complement, 2's complement), LSB-first over WIDTH cycles. It uses the same function-select encodings as the team's combinational adder. It is the area-cheap inverse-operation companion to that adder, for datapaths that tolerate multi-cycle latency. Valid/ready handshakes are used on both input and output.

## Interface
- `WIDTH`, default 4: operand/result width in bits; minimum 2.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `f_i`  in  2  format select; sampled at accept
- `a_i`  in  WIDTH  minuend; sampled at accept
- `b_i`  in  WIDTH  subtrahend; sampled at accept
- `valid_i`  in  1  operands valid
- `ready_o`  out  1  block can accept operands
- `y_o`  out  WIDTH  difference
- `flag_o`  out  1  unsigned: borrow; 1's/2's complement: signed overflow
- `valid_o`  out  1  result valid
- `ready_i`  in  1  consumer accepts result

## Operation
- Encodings (shared):
  - `adder_unsigned` = 2'b00
  - `adder_1sComplement` = 2'b01
  - `adder_2sComplement` = 2'b10
  - 2'b11 reserved
- Computation is `a + ~b + cin`, one bit per cycle via a serial full-adder with a carry flop.
  - `cin` = 1 for unsigned and 2's complement; `cin` = 0 for 1's complement.
- States:
  - IDLE: `ready_o`=1. On `valid_i && ready_o`, latch `f_i`, `a_i`, `~b_i`, load carry with `cin`, clear bit counter, go to SUB.
  - SUB: process bit `cnt`; result shifts in at MSB. After bit WIDTH-1, with final carry `c`:
    - 1's complement and `c`=1: go to WRAP, carry reloaded to 1.
    - Otherwise: go to DONE.
  - WRAP (1's complement end-around carry only): serially add carry to the stored result over exactly WIDTH cycles (fixed, no early exit), then go to DONE.
  - DONE: `valid_o`=1; `y_o`/`flag_o` held stable. On `ready_i`, go to IDLE.
- Flags:
  - Unsigned: `flag_o` = ~`c` (borrow, i.e. a<b). `y_o` = (a-b) mod 2^WIDTH.
  - 2's complement: `y_o` = (a-b) mod 2^WIDTH.
  - 1's and 2's complement: `flag_o` = (a[MSB]≠b[MSB]) && (y[MSB]≠a[MSB]), using the final `y`.
  - 1's complement, a==b: result is all-ones (negative zero); no WRAP pass.
- Reserved `f_i`=2'b11: processed like 2's complement timing; `y_o`=0, `flag_o`=0.
- Input changes after accept are ignored. `valid_i` is ignored outside IDLE.

## Timing
- Reset values: `y_o`=0, `flag_o`=0, `valid_o`=0, state IDLE, `ready_o`=1 from the first cycle after reset.
- `ready_o` and `valid_o` are decoded from registered state only, with no combinational path from inputs.
- Accept at edge k:
  - `ready_o` low from k+1.
  - Bit i is processed in cycle k+1+i.
  - `valid_o` is high from k+WIDTH+1, or from k+2·WIDTH+1 when WRAP is taken.
- Output transfer at edge m (`valid_o && ready_i`): `valid_o`=0 and `ready_o`=1 from m+1. No new accept occurs in the transfer cycle itself.
- `ready_i` low: DONE is held indefinitely and outputs stay stable.
- `rst` in any state: abort next edge, discard the in-flight result, outputs return to reset values.

## Configuration
- `SERIAL_SUB_CHECK_EN` defined:
  - Simulation-only `$warning` when a reserved `f_i` is accepted.
  - Simulation-only `$warning` when `valid_o` drops or `y_o` changes in DONE without `ready_i`.
- `SERIAL_SUB_CHECK_EN` undefined: checks are compiled out; functional behaviour is identical.

## Structure
- Shared `define.vh`:
  - format encodings (`adder_unsigned`, `adder_1sComplement`, `adder_2sComplement`)
  - state encodings IDLE/SUB/WRAP/DONE
- Sub-module `serial_fa_cell`: 1-bit full adder with registered carry and a synchronous carry-load port. It is reused for the SUB and WRAP passes.
- Top level holds the FSM, bit counter ($clog2(WIDTH) bits), operand/result shift registers, and flag logic.

## Test plan (WIDTH=4)
- Unsigned, 5−3, `ready_i`=1 → `y_o`=4'h2, `flag_o`=0, `valid_o` at accept+5.
- Unsigned, 3−5 → `y_o`=4'hE, `flag_o`=1 (borrow).
- 2's complement, 4'h7 − 4'hF → `y_o`=4'h8, `flag_o`=1. Also 4'hE − 4'h1 → `y_o`=4'hD, `flag_o`=0.
- 1's complement:
  - 5−2 → WRAP taken, `y_o`=4'h3, `valid_o` at accept+9.
  - 2−2 → `y_o`=4'hF, no WRAP, `valid_o` at accept+5.
- Backpressure: hold `ready_i`=0 for 3 cycles in DONE while toggling `valid_i`/`a_i` → `y_o` stable, `ready_o`=0, no new accept. Release → `ready_o`=1 next cycle.
- Assert `rst` at accept+2 mid-SUB → next cycle `valid_o`=0, `y_o`=0, `flag_o`=0, `ready_o`=1. A subsequent 5−3 unsigned yields 4'h2.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared encodings for the bit-serial subtractor: number formats (same codes as the
// combinational adder), FSM states and small arithmetic helpers.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ADDER_UNSIGNED      = 2'b00,
        ADDER_1S_COMPLEMENT = 2'b01,
        ADDER_2S_COMPLEMENT = 2'b10,
        ADDER_RESERVED      = 2'b11
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SUB  = 2'b01,
        ST_WRAP = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // a - b is built as a + ~b + cin; 1's complement fixes up with end-around carry instead
    function automatic logic carry_in_for(input fmt_e fmt);
        logic cin;
        case (fmt)
            ADDER_1S_COMPLEMENT: cin = 1'b0;
            default:             cin = 1'b1;
        endcase
        return cin;
    endfunction

    function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic y_msb);
        return (a_msb ^ b_msb) & (y_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder with a registered carry. The carry can be loaded synchronously,
// which is how each SUB and WRAP pass seeds its initial carry.
module serial_fa_cell (
    input  logic clk,
    input  logic rst,
    input  logic a_i,
    input  logic b_i,
    input  logic en_i,
    input  logic load_i,
    input  logic load_val_i,
    output logic sum_o,
    output logic cout_o
);

    logic carry_q;
    logic carry_d;

    assign sum_o  = a_i ^ b_i ^ carry_q;
    assign cout_o = (a_i & b_i) | (a_i & carry_q) | (b_i & carry_q);

    // Next carry: a load wins over normal accumulation
    always_comb begin
        carry_d = carry_q;
        if (load_i) begin
            carry_d = load_val_i;
        end else if (en_i) begin
            carry_d = cout_o;
        end else begin
            carry_d = carry_q;
        end
    end

    // Carry flop
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a_i - b_i (unsigned / 1's / 2's complement), LSB first, valid/ready on both sides.
// Define SERIAL_SUB_CHECK_EN to enable simulation-only protocol warnings.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       f_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] y_o,
    output logic             flag_o,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    fmt_e             fmt_q, fmt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] nb_q, nb_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             flag_q, flag_d;

    logic last_bit_s;
    logic wrap_s;
    logic fa_a_s, fa_b_s, fa_en_s, fa_load_s, fa_load_val_s;
    logic fa_sum_s, fa_cout_s;

    assign last_bit_s = (cnt_q == CNT_LAST);
    assign wrap_s     = (fmt_q == ADDER_1S_COMPLEMENT) && fa_cout_s;

    serial_fa_cell u_fa (
        .clk        (clk),
        .rst        (rst),
        .a_i        (fa_a_s),
        .b_i        (fa_b_s),
        .en_i       (fa_en_s),
        .load_i     (fa_load_s),
        .load_val_i (fa_load_val_s),
        .sum_o      (fa_sum_s),
        .cout_o     (fa_cout_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) state_d = ST_SUB;
                else         state_d = ST_IDLE;
            end
            ST_SUB: begin
                if (last_bit_s) state_d = wrap_s ? ST_WRAP : ST_DONE;
                else            state_d = ST_SUB;
            end
            ST_WRAP: begin
                if (last_bit_s) state_d = ST_DONE;
                else            state_d = ST_WRAP;
            end
            ST_DONE: begin
                if (ready_i) state_d = ST_IDLE;
                else         state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register only
    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_q)
            ST_IDLE: ready_o = 1'b1;
            ST_DONE: valid_o = 1'b1;
            default: begin
                ready_o = 1'b0;
                valid_o = 1'b0;
            end
        endcase
    end

    assign y_o    = y_q;
    assign flag_o = flag_q;

    // Datapath next-state: operand/result shifting, adder steering and flag capture
    always_comb begin
        fmt_d         = fmt_q;
        a_d           = a_q;
        nb_d          = nb_q;
        y_d           = y_q;
        cnt_d         = cnt_q;
        a_msb_d       = a_msb_q;
        b_msb_d       = b_msb_q;
        flag_d        = flag_q;
        fa_a_s        = 1'b0;
        fa_b_s        = 1'b0;
        fa_en_s       = 1'b0;
        fa_load_s     = 1'b0;
        fa_load_val_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    fmt_d         = fmt_e'(f_i);
                    a_d           = a_i;
                    nb_d          = ~b_i;
                    a_msb_d       = a_i[WIDTH-1];
                    b_msb_d       = b_i[WIDTH-1];
                    y_d           = '0;
                    flag_d        = 1'b0;
                    cnt_d         = '0;
                    fa_load_s     = 1'b1;
                    fa_load_val_s = carry_in_for(fmt_e'(f_i));
                end else begin
                    fa_load_s = 1'b0;
                end
            end
            ST_SUB: begin
                fa_a_s  = a_q[0];
                fa_b_s  = nb_q[0];
                fa_en_s = 1'b1;
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                nb_d    = {1'b0, nb_q[WIDTH-1:1]};
                y_d     = {fa_sum_s, y_q[WIDTH-1:1]};
                if (last_bit_s) begin
                    cnt_d = '0;
                    case (fmt_q)
                        ADDER_UNSIGNED: flag_d = ~fa_cout_s;
                        ADDER_1S_COMPLEMENT: begin
                            // End-around carry pending: flag is decided after WRAP
                            if (fa_cout_s) begin
                                fa_load_s     = 1'b1;
                                fa_load_val_s = 1'b1;
                            end else begin
                                flag_d = sub_overflow(a_msb_q, b_msb_q, fa_sum_s);
                            end
                        end
                        ADDER_2S_COMPLEMENT: flag_d = sub_overflow(a_msb_q, b_msb_q, fa_sum_s);
                        default: begin
                            y_d    = '0;
                            flag_d = 1'b0;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WRAP: begin
                // Ripple the end-around carry through the stored result, one full rotation
                fa_a_s  = y_q[0];
                fa_b_s  = 1'b0;
                fa_en_s = 1'b1;
                y_d     = {fa_sum_s, y_q[WIDTH-1:1]};
                if (last_bit_s) begin
                    cnt_d  = '0;
                    flag_d = sub_overflow(a_msb_q, b_msb_q, fa_sum_s);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                fa_en_s = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fmt_q   <= ADDER_UNSIGNED;
            a_q     <= '0;
            nb_q    <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            fmt_q   <= fmt_d;
            a_q     <= a_d;
            nb_q    <= nb_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            flag_q  <= flag_d;
        end
    end

`ifdef SERIAL_SUB_CHECK_EN
    logic [WIDTH-1:0] chk_y_prev_q;
    logic             chk_hold_q;

    // Simulation-only protocol monitors
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_y_prev_q <= '0;
            chk_hold_q   <= 1'b0;
        end else begin
            if (ready_o && valid_i && (f_i == 2'b11)) begin
                $warning("serial_subtractor: reserved format accepted");
            end
            if (chk_hold_q && (!valid_o || (y_o != chk_y_prev_q))) begin
                $warning("serial_subtractor: result changed in DONE without ready_i");
            end
            chk_y_prev_q <= y_o;
            chk_hold_q   <= valid_o && !ready_i;
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): directed cases, randomized
// transactions against an arithmetic reference model, backpressure and reset abort.
module tb_serial_subtractor;

    localparam int W = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic [1:0]   f_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] y_o;
    logic         flag_o;
    logic         valid_o;
    logic         ready_i;

    int n_checks = 0;
    int n_errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .f_i     (f_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .y_o     (y_o),
        .flag_o  (flag_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: difference, flag and cycles from accept to valid_o
    function automatic void model(input int f, input int a, input int b,
                                  output int y, output int flag, output int lat);
        int s, sa, sb, d, msb;
        msb = W - 1;
        lat = W;
        case (f)
            0: begin
                y    = (a - b) & MASK;
                flag = (a < b) ? 1 : 0;
            end
            1: begin
                s = a + ((~b) & MASK);
                if (s > MASK) begin
                    y   = s - MASK;
                    lat = 2 * W;
                end else begin
                    y = s;
                end
                flag = ((((a >> msb) & 1) != ((b >> msb) & 1)) &&
                        (((y >> msb) & 1) != ((a >> msb) & 1))) ? 1 : 0;
            end
            2: begin
                y    = (a - b) & MASK;
                sa   = (a > (MASK >> 1)) ? a - (MASK + 1) : a;
                sb   = (b > (MASK >> 1)) ? b - (MASK + 1) : b;
                d    = sa - sb;
                flag = (d > (MASK >> 1) || d < -((MASK + 1) >> 1)) ? 1 : 0;
            end
            default: begin
                y    = 0;
                flag = 0;
            end
        endcase
    endfunction

    // One transaction: accept, latency, result, optional DONE hold, release
    task automatic run_txn(input int f, input int a, input int b, input int hold);
        int exp_y, exp_flag, exp_lat, t, cycles;
        logic [W-1:0] y_seen;
        model(f, a, b, exp_y, exp_flag, exp_lat);
        ready_i = (hold == 0);
        t = 0;
        while (!ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL ready_wait: ready_o=%b required 1", ready_o);
        end
        f_i = 2'(f); a_i = 4'(a); b_i = 4'(b); valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        a_i = 4'($urandom_range(MASK, 0));
        b_i = 4'($urandom_range(MASK, 0));
        f_i = 2'($urandom_range(3, 0));
        n_checks++;
        if (ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL ready_low: ready_o=%b required 0", ready_o);
        end
        cycles = 0;
        while (valid_o !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        n_checks++;
        if (cycles !== exp_lat) begin
            n_errors++;
            $display("FAIL latency f=%0d a=%0d b=%0d: got %0d cycles required %0d", f, a, b, cycles, exp_lat);
        end
        n_checks++;
        if (y_o !== 4'(exp_y) || flag_o !== 1'(exp_flag) || ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL result f=%0d a=%0d b=%0d: y=%h flag=%b ready=%b required y=%h flag=%0d ready=0",
                     f, a, b, y_o, flag_o, ready_o, exp_y[W-1:0], exp_flag);
        end
        y_seen = y_o;
        for (int i = 0; i < hold; i++) begin
            valid_i = 1'($urandom_range(1, 0));
            a_i = 4'($urandom_range(MASK, 0));
            @(negedge clk);
            n_checks++;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || y_o !== y_seen) begin
                n_errors++;
                $display("FAIL hold[%0d]: valid=%b ready=%b y=%h required valid=1 ready=0 y=%h",
                         i, valid_o, ready_o, y_o, y_seen);
            end
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL release: valid=%b ready=%b required valid=0 ready=1", valid_o, ready_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        f_i = 2'b00; a_i = '0; b_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || y_o !== 4'h0 || flag_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: ready=%b valid=%b y=%h flag=%b required 1 0 0 0",
                     ready_o, valid_o, y_o, flag_o);
        end
    endtask

    task automatic test_directed();
        run_txn(0, 5, 3, 0);       // 2, no borrow
        run_txn(0, 3, 5, 0);       // E, borrow
        run_txn(2, 7, 15, 0);      // 8, overflow
        run_txn(2, 14, 1, 0);      // D
        run_txn(1, 5, 2, 0);       // WRAP, 3
        run_txn(1, 2, 2, 0);       // negative zero
        run_txn(3, 9, 4, 0);       // reserved
        run_txn(0, 0, 15, 0);
        run_txn(2, 8, 1, 0);
    endtask

    task automatic test_backpressure();
        run_txn(0, 5, 3, 3);
        run_txn(1, 6, 1, 2);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_txn($urandom_range(3, 0), $urandom_range(MASK, 0), $urandom_range(MASK, 0),
                    $urandom_range(2, 0));
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) begin
            run_txn(n % 3, $urandom_range(MASK, 0), $urandom_range(MASK, 0), 0);
        end
    endtask

    task automatic test_reset_mid_sub();
        @(negedge clk);
        f_i = 2'b00; a_i = 4'd3; b_i = 4'd0; valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0 || y_o !== 4'h0 || flag_o !== 1'b0 || ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_sub: valid=%b y=%h flag=%b ready=%b required 0 0 0 1",
                     valid_o, y_o, flag_o, ready_o);
        end
        run_txn(0, 5, 3, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_mid_sub();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
